// File: rtl/quat_mult_seq.sv
// Sequential Hamilton quaternion multiplier: q = a*b, or a*conj(b), built from four
// radix-4 Booth lanes that each walk the four signed product terms of one output component.
module quat_mult_seq #(
    parameter  int W  = 16,
    localparam int OW = 2*W+2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          conj_b,
    input  logic [W-1:0]  a0,
    input  logic [W-1:0]  a1,
    input  logic [W-1:0]  a2,
    input  logic [W-1:0]  a3,
    input  logic [W-1:0]  b0,
    input  logic [W-1:0]  b1,
    input  logic [W-1:0]  b2,
    input  logic [W-1:0]  b3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] q0,
    output logic [OW-1:0] q1,
    output logic [OW-1:0] q2,
    output logic [OW-1:0] q3,
    output logic          busy
);

    localparam int CW = $clog2(W/2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          conj_q;
    logic [1:0]    term_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_q [4];
    logic [W-1:0]  b_q [4];

    logic [W-1:0]  a_in_s [4];
    logic [W-1:0]  b_in_s [4];
    logic          accept_s;
    logic          last_step_s;
    logic [1:0]    term_nx_s;
    logic [W-1:0]  mcand_s;
    logic [W+1:0]  mcand_x_s;
    logic [W+1:0]  mcand_2x_s;

    // Term sign for a lane. Lane k takes b index k^term for every term, so the only
    // per-lane data is which terms subtract; conjugation flips every imaginary-b term.
    function automatic logic term_neg(input logic [1:0] lane, input logic [1:0] term,
                                      input logic conj);
        logic [3:0] pat;
        logic       neg;
        case (lane)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1000;
            2'd2:    pat = 4'b0010;
            2'd3:    pat = 4'b0100;
            default: pat = 4'b0000;
        endcase
        neg = pat[term];
        if (conj && ((lane ^ term) != 2'd0)) begin
            neg = ~neg;
        end else begin
            neg = neg;
        end
        return neg;
    endfunction

    assign a_in_s[0] = a0;
    assign a_in_s[1] = a1;
    assign a_in_s[2] = a2;
    assign a_in_s[3] = a3;
    assign b_in_s[0] = b0;
    assign b_in_s[1] = b1;
    assign b_in_s[2] = b2;
    assign b_in_s[3] = b3;

    // Shared control decode and the multiplicand, which is a[term] for every lane.
    always_comb begin
        accept_s    = in_valid && in_ready_q;
        last_step_s = (cnt_q == CW'(W/2 - 1));
        term_nx_s   = term_q + 2'd1;
        mcand_s     = a_q[term_q];
        mcand_x_s   = {{2{mcand_s[W-1]}}, mcand_s};
        mcand_2x_s  = {mcand_s[W-1], mcand_s, 1'b0};
    end

    // Control FSM: operand capture, step/term sequencing and the handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            conj_q      <= 1'b0;
            term_q      <= 2'd0;
            cnt_q       <= {CW{1'b0}};
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= {W{1'b0}};
                b_q[i] <= {W{1'b0}};
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < 4; i++) begin
                            a_q[i] <= a_in_s[i];
                            b_q[i] <= b_in_s[i];
                        end
                        conj_q     <= conj_b;
                        term_q     <= 2'd0;
                        cnt_q      <= {CW{1'b0}};
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (last_step_s) begin
                        cnt_q   <= {CW{1'b0}};
                        state_q <= S_ACC;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                S_ACC: begin
                    if (term_q == 2'd3) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        term_q  <= term_nx_s;
                        state_q <= S_MUL;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar l = 0; l < 4; l++) begin : lane_g
        localparam logic [1:0] LANE = 2'(l);

        logic [W+1:0]   p_q;
        logic [W-1:0]   m_q;
        logic           x_q;
        logic [OW-1:0]  acc_q;
        logic [OW-1:0]  q_q;

        logic [W+1:0]   addend_s;
        logic [W+1:0]   sum_s;
        logic [2*W+1:0] shift_s;
        logic [W+1:0]   p_d;
        logic [W-1:0]   m_d;
        logic [OW-1:0]  prod_s;
        logic           neg_s;
        logic [OW-1:0]  acc_d;

        // One Booth step on {partial, multiplier}; after W/2 steps that pair is the
        // exact product, already sign-extended to the accumulator width.
        always_comb begin
            addend_s = {(W+2){1'b0}};
            case ({m_q[1:0], x_q})
                3'b001, 3'b010: addend_s = mcand_x_s;
                3'b011:         addend_s = mcand_2x_s;
                3'b100:         addend_s = {(W+2){1'b0}} - mcand_2x_s;
                3'b101, 3'b110: addend_s = {(W+2){1'b0}} - mcand_x_s;
                default:        addend_s = {(W+2){1'b0}};
            endcase
            sum_s   = p_q + addend_s;
            shift_s = $signed({sum_s, m_q}) >>> 2;
            p_d     = shift_s[2*W+1:W];
            m_d     = shift_s[W-1:0];
            prod_s  = {p_q, m_q};
            neg_s   = term_neg(LANE, term_q, conj_q);
            acc_d   = neg_s ? (acc_q - prod_s) : (acc_q + prod_s);
        end

        // Lane datapath: load multiplier per term, shift during MUL, fold in during ACC.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                p_q   <= {(W+2){1'b0}};
                m_q   <= {W{1'b0}};
                x_q   <= 1'b0;
                acc_q <= {OW{1'b0}};
                q_q   <= {OW{1'b0}};
            end else if (accept_s) begin
                p_q   <= {(W+2){1'b0}};
                m_q   <= b_in_s[LANE];
                x_q   <= 1'b0;
                acc_q <= {OW{1'b0}};
            end else if (state_q == S_MUL) begin
                p_q <= p_d;
                m_q <= m_d;
                x_q <= m_q[1];
            end else if (state_q == S_ACC) begin
                acc_q <= acc_d;
                p_q   <= {(W+2){1'b0}};
                m_q   <= b_q[LANE ^ term_nx_s];
                x_q   <= 1'b0;
                if (term_q == 2'd3) begin
                    q_q <= acc_d;
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign q0        = lane_g[0].q_q;
    assign q1        = lane_g[1].q_q;
    assign q2        = lane_g[2].q_q;
    assign q3        = lane_g[3].q_q;

endmodule
